timer_irq_ctrl: RTL and testbench

- Memory-mapped control and interrupt front end for the digital interval timer.
- Drives the timer's programming side (`timer_set_val`, `set_timer`) and consumes its expiry pulse (`timer_is_high`).
- Latches each expiry into a sticky pending bit, raises `irq`, and counts expirations.
- Sits between the core's simple register bus and the timer instance.

---
 rtl/timer_irq_ctrl_pkg.sv | 34 +++
 rtl/timer_irq_ctrl_if.sv | 28 ++
 rtl/timer_irq_ctrl_regs.sv | 153 +++++++++++++++
 rtl/timer_irq_ctrl.sv | 96 +++++++++
 tb/tb_timer_irq_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_irq_pkg
// Description : Shared constants and state type for the timer IRQ controller:
//               register byte offsets, CTRL/STATUS bit positions, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_irq_pkg;

  // Register byte offsets on the 4-bit bus address
  localparam logic [3:0] c_addr_ctrl   = 4'h0;
  localparam logic [3:0] c_addr_load   = 4'h4;
  localparam logic [3:0] c_addr_status = 4'h8;
  localparam logic [3:0] c_addr_count  = 4'hC;

  // CTRL bit positions
  localparam int c_ctrl_en       = 0;
  localparam int c_ctrl_periodic = 1;
  localparam int c_ctrl_ie       = 2;

  // STATUS bit positions
  localparam int c_stat_pending  = 0;
  localparam int c_stat_overrun  = 1;

  // Controller states; ARM and PARK each last exactly one cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    PARK = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/timer_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_irq_ctrl_if
// Description : Simple register bus between the core (master) and the timer
//               IRQ controller (slave). One-cycle request, registered ack.
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_irq_ctrl_if;

  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );

endinterface
`default_nettype wire

// File: rtl/timer_irq_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : timer_irq_regs
// Description : Bus decode, CTRL/LOAD/STATUS/COUNT registers, read mux and
//               bus acknowledge for the timer IRQ controller. Reports EN
//               edges and LOAD writes to the controlling state machine.
//               Optional macro TIMER_IRQ_OVERRUN_EN adds STATUS.OVERRUN.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_irq_regs
  import timer_irq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  timer_irq_ctrl_if.slave bus,
  input  logic        i_expiry,       // expiry accepted this cycle
  input  logic        i_oneshot_clr,  // one-shot expiry: drop EN
  output logic        o_periodic,
  output logic        o_en_rise,      // CTRL write taking EN 0->1
  output logic        o_en_fall,      // CTRL write taking EN 1->0
  output logic        o_load_wr,
  output logic [31:0] o_load,
  output logic        o_irq
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic             r_en;
  logic             r_periodic;
  logic             r_ie;
  logic [31:0]      r_load;
  logic             r_pending;
  logic [CNT_W-1:0] r_count;
  logic             r_ack;
  logic [31:0]      r_rdata;

  logic             w_wr;
  logic             w_rd;
  logic             w_ctrl_wr;
  logic             w_load_wr;
  logic             w_status_wr;
  logic             w_count_wr;
  logic             w_overrun;
  logic [31:0]      w_rd_mux;

  assign w_wr        = bus.bus_req & bus.bus_we;
  assign w_rd        = bus.bus_req & ~bus.bus_we;
  assign w_ctrl_wr   = w_wr & (bus.bus_addr == c_addr_ctrl);
  assign w_load_wr   = w_wr & (bus.bus_addr == c_addr_load);
  assign w_status_wr = w_wr & (bus.bus_addr == c_addr_status);
  assign w_count_wr  = w_wr & (bus.bus_addr == c_addr_count);

  assign o_en_rise  = w_ctrl_wr &  bus.bus_wdata[c_ctrl_en] & ~r_en;
  assign o_en_fall  = w_ctrl_wr & ~bus.bus_wdata[c_ctrl_en] &  r_en;
  assign o_load_wr  = w_load_wr;
  assign o_load     = r_load;
  assign o_periodic = r_periodic;
  assign o_irq      = r_pending & r_ie;

  // CTRL and LOAD; a one-shot expiry clears EN even against a same-cycle write
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_ie       <= 1'b0;
      r_load     <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_en       <= bus.bus_wdata[c_ctrl_en];
        r_periodic <= bus.bus_wdata[c_ctrl_periodic];
        r_ie       <= bus.bus_wdata[c_ctrl_ie];
      end
      if (i_oneshot_clr) begin
        r_en <= 1'b0;
      end
      if (w_load_wr) begin
        r_load <= bus.bus_wdata;
      end
    end
  end

  // Sticky PENDING; a same-cycle expiry beats the write-1-to-clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= 1'b0;
    end else if (i_expiry) begin
      r_pending <= 1'b1;
    end else if (w_status_wr && bus.bus_wdata[c_stat_pending]) begin
      r_pending <= 1'b0;
    end
  end

`ifdef TIMER_IRQ_OVERRUN_EN
  logic r_overrun;

  // OVERRUN flags an expiry that lands on a still-pending one; set beats clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (i_expiry && r_pending) begin
      r_overrun <= 1'b1;
    end else if (w_status_wr && bus.bus_wdata[c_stat_overrun]) begin
      r_overrun <= 1'b0;
    end
  end

  assign w_overrun = r_overrun;
`else
  assign w_overrun = 1'b0;
`endif

  // Saturating expiry counter; any COUNT write clears it, keeping a same-cycle expiry
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_count_wr) begin
      r_count <= i_expiry ? c_cnt_one : '0;
    end else if (i_expiry && (r_count != c_cnt_max)) begin
      r_count <= r_count + c_cnt_one;
    end
  end

  // Read mux over the register values present in the access cycle
  always_comb begin
    w_rd_mux = '0;
    case (bus.bus_addr)
      c_addr_ctrl:   w_rd_mux = {29'd0, r_ie, r_periodic, r_en};
      c_addr_load:   w_rd_mux = r_load;
      c_addr_status: w_rd_mux = {30'd0, w_overrun, r_pending};
      c_addr_count:  w_rd_mux = 32'(r_count);
      default:       w_rd_mux = '0;
    endcase
  end

  // Every access, defined offset or not, is acknowledged one cycle later
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= bus.bus_req;
      r_rdata <= w_rd ? w_rd_mux : '0;
    end
  end

  assign bus.bus_ack   = r_ack;
  assign bus.bus_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_irq_ctrl
// Description : Control and interrupt front end for the interval timer.
//               Programs the timer (ARM with LOAD, PARK with PARK_VAL),
//               accepts expiry pulses while running, raises a level IRQ.
//               Optional macro TIMER_IRQ_OVERRUN_EN adds STATUS.OVERRUN.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] PARK_VAL = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  timer_irq_ctrl_if.slave bus,
  output logic [31:0] timer_set_val,
  output logic        set_timer,
  input  logic        timer_is_high,
  output logic        irq
);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_expiry;
  logic        w_oneshot_clr;
  logic        w_periodic;
  logic        w_en_rise;
  logic        w_en_fall;
  logic        w_load_wr;
  logic [31:0] w_load;

  // Pulses outside RUN (idle, or stale ones during the ARM strobe) are dropped
  assign w_expiry      = (r_state == RUN) & timer_is_high;
  assign w_oneshot_clr = w_expiry & ~w_periodic;

  timer_irq_regs #(
    .CNT_W (CNT_W)
  ) u_regs (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .i_expiry      (w_expiry),
    .i_oneshot_clr (w_oneshot_clr),
    .o_periodic    (w_periodic),
    .o_en_rise     (w_en_rise),
    .o_en_fall     (w_en_fall),
    .o_load_wr     (w_load_wr),
    .o_load        (w_load),
    .o_irq         (irq)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and timer programming strobe. EN is 1 exactly in ARM/RUN, so
  // an EN edge written during a one-cycle strobe state is honoured there too.
  always_comb begin
    w_state_nxt   = r_state;
    set_timer     = 1'b0;
    timer_set_val = '0;
    case (r_state)
      IDLE: begin
        if (w_en_rise) w_state_nxt = ARM;
      end
      ARM: begin
        set_timer     = 1'b1;
        timer_set_val = w_load;
        if (w_en_fall)      w_state_nxt = PARK;
        else if (w_load_wr) w_state_nxt = ARM;
        else                w_state_nxt = RUN;
      end
      RUN: begin
        if (w_oneshot_clr || w_en_fall) w_state_nxt = PARK;
        else if (w_load_wr)             w_state_nxt = ARM;
      end
      PARK: begin
        set_timer     = 1'b1;
        timer_set_val = PARK_VAL;
        w_state_nxt   = w_en_rise ? ARM : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_irq_ctrl
// Description : Self-checking bench for timer_irq_ctrl: register table,
//               directed timing/corner sequences with a timer model, and a
//               randomized run against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_irq_ctrl;

  localparam int          CNT_W = 4;
  localparam logic [31:0] PARK  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] timer_set_val;
  logic        set_timer;
  logic        timer_is_high;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobe = 0;

  timer_irq_ctrl_if bus_if ();

  timer_irq_ctrl #(
    .CNT_W    (CNT_W),
    .PARK_VAL (PARK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if),
    .timer_set_val (timer_set_val),
    .set_timer     (set_timer),
    .timer_is_high (timer_is_high),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Timer model: expires N+1 cycles after being programmed with N, then repeats
  logic        use_model = 1'b0;
  logic        manual_pulse = 1'b0;
  logic [31:0] t_cnt = '0;
  logic [31:0] t_val = '0;
  logic        t_live = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      t_live <= 1'b0;
    end else if (set_timer) begin
      t_cnt  <= timer_set_val;
      t_val  <= timer_set_val;
      t_live <= 1'b1;
    end else if (t_live) begin
      t_cnt <= (t_cnt == 32'd0) ? t_val : t_cnt - 32'd1;
    end
  end

  always @(posedge clk) if (set_timer === 1'b1) n_strobe <= n_strobe + 1;

  assign timer_is_high = use_model ? (t_live && (t_cnt == 32'd0)) : manual_pulse;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.bus_req   = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = 4'h0;
    bus_if.bus_wdata = 32'h0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = a; bus_if.bus_wdata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = a; bus_if.bus_wdata = 32'h0;
    @(negedge clk);
    bus_idle();
    check("read_ack", {31'd0, bus_if.bus_ack}, 32'd1);
    d = bus_if.bus_rdata;
  endtask

  task automatic read_check(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(nm, d, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; manual_pulse = 1'b0; bus_idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Bounded wait for irq; returns negedges elapsed (40 means it never came)
  task automatic wait_irq(output int k);
    k = 0;
    while (irq !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic pulse_once();
    @(negedge clk); manual_pulse = 1'b1;
    @(negedge clk); manual_pulse = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  // EN high means the timer is live. An EN rise, or a reload while live,
  // programs the timer with LOAD; an EN fall (written, or the one-shot
  // self-clear) parks it. Expiries only count while live and not arming.
  logic        m_en, m_per, m_ie, m_pend, m_ovr, m_ack, m_rd;
  logic [31:0] m_load, m_rdata;
  int          m_cnt;
  int          m_strobe;  // 0 none, 1 program with LOAD, 2 park

  task automatic model_reset();
    m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_ovr = 0; m_ack = 0; m_rd = 0;
    m_load = 0; m_rdata = 0; m_cnt = 0; m_strobe = 0;
  endtask

  task automatic model_step(input logic req, input logic we, input logic [3:0] a,
                            input logic [31:0] wd, input logic tih);
    logic acc, en_n;
    acc = tih && m_en && (m_strobe != 1);
    m_ack = req;
    m_rd  = req && !we;
    m_rdata = 0;
    if (m_rd) begin
      if (a == 4'h0)      m_rdata = {29'd0, m_ie, m_per, m_en};
      else if (a == 4'h4) m_rdata = m_load;
      else if (a == 4'h8) m_rdata = {30'd0, m_ovr, m_pend};
      else if (a == 4'hC) m_rdata = m_cnt;
    end
    en_n = (req && we && a == 4'h0) ? wd[0] : m_en;
    if (acc && !m_per) en_n = 0;
    if (!m_en && en_n)                           m_strobe = 1;
    else if (m_en && !en_n)                      m_strobe = 2;
    else if (m_en && req && we && a == 4'h4)     m_strobe = 1;
    else                                         m_strobe = 0;
    if (req && we && a == 4'h0) begin m_per = wd[1]; m_ie = wd[2]; end
    if (req && we && a == 4'h4) m_load = wd;
`ifdef TIMER_IRQ_OVERRUN_EN
    if (acc && m_pend) m_ovr = 1;
    else if (req && we && a == 4'h8 && wd[1]) m_ovr = 0;
`endif
    if (acc) m_pend = 1;
    else if (req && we && a == 4'h8 && wd[0]) m_pend = 0;
    if (req && we && a == 4'hC) m_cnt = acc ? 1 : 0;
    else if (acc && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    m_en = en_n;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int k;
    logic [31:0] rd;
    logic [31:0] exp_st;
    int base;

    bus_idle();
    // --- reset state ---
    repeat (3) @(negedge clk);
    check("rst_set_timer", {31'd0, set_timer}, 32'd0);
    check("rst_set_val", timer_set_val, 32'd0);
    check("rst_ack", {31'd0, bus_if.bus_ack}, 32'd0);
    check("rst_rdata", bus_if.bus_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;

    // --- stale pulse in IDLE ---
    pulse_once();
    read_check("idle_status", 4'h8, 32'h0);
    read_check("idle_count", 4'hC, 32'h0);

    // --- register access table (EN kept 0) ---
    tbl[0]  = '{1'b1, 4'h4, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 4'h4, 32'h0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 4'h0, 32'h0, 32'h0};
    tbl[3]  = '{1'b1, 4'h0, 32'h0000_0006, 32'h0};
    tbl[4]  = '{1'b0, 4'h0, 32'h0, 32'h6};
    tbl[5]  = '{1'b1, 4'h3, 32'hFFFF_FFFF, 32'h0};
    tbl[6]  = '{1'b0, 4'h0, 32'h0, 32'h6};
    tbl[7]  = '{1'b0, 4'h3, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 4'h7, 32'h0, 32'h0};
    tbl[9]  = '{1'b0, 4'h8, 32'h0, 32'h0};
    tbl[10] = '{1'b1, 4'h0, 32'hFFFF_FFF8, 32'h0};
    tbl[11] = '{1'b0, 4'h0, 32'h0, 32'h0};
    tbl[12] = '{1'b1, 4'hC, 32'h1234_5678, 32'h0};
    tbl[13] = '{1'b0, 4'hC, 32'h0, 32'h0};
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].we) begin
        bus_write(tbl[i].addr, tbl[i].wdata);
        check($sformatf("tbl%0d_no_strobe", i), {31'd0, set_timer}, 32'd0);
      end else begin
        bus_read(tbl[i].addr, rd);
        check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      end
    end

    // --- stale pulse during ARM, then PARK strobe ---
    bus_write(4'h4, 32'd50);
    bus_write(4'h0, 32'h5);
    check("arm_strobe", {31'd0, set_timer}, 32'd1);
    check("arm_val", timer_set_val, 32'd50);
    manual_pulse = 1'b1;
    @(negedge clk);
    manual_pulse = 1'b0;
    check("arm_one_cycle", {31'd0, set_timer}, 32'd0);
    read_check("arm_stale_status", 4'h8, 32'h0);
    read_check("arm_stale_count", 4'hC, 32'h0);
    bus_write(4'h0, 32'h0);
    check("park_strobe", {31'd0, set_timer}, 32'd1);
    check("park_val", timer_set_val, PARK);

    // --- reset during RUN aborts a re-arm strobe ---
    bus_write(4'h0, 32'h5);
    @(negedge clk);
    pulse_once();
    check("run_irq", {31'd0, irq}, 32'd1);
    rst = 1'b0;
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = 4'h4; bus_if.bus_wdata = 32'd7;
    @(negedge clk);
    bus_idle();
    check("midrst_set_timer", {31'd0, set_timer}, 32'd0);
    check("midrst_val", timer_set_val, 32'd0);
    check("midrst_ack", {31'd0, bus_if.bus_ack}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    read_check("midrst_ctrl", 4'h0, 32'h0);
    pulse_once();
    read_check("midrst_count", 4'hC, 32'h0);

    // --- periodic mode with timer model ---
    do_reset();
    use_model = 1'b1;
    bus_write(4'h4, 32'd5);
    bus_write(4'h0, 32'h7);
    check("per_strobe", {31'd0, set_timer}, 32'd1);
    check("per_val", timer_set_val, 32'd5);
    base = n_strobe;
    wait_irq(k);
    check("per_first_irq_delay", k, 32'd7);
    repeat (12) @(negedge clk);
    read_check("per_count3", 4'hC, 32'd3);
    bus_write(4'h8, 32'h1);
    check("per_irq_cleared", {31'd0, irq}, 32'd0);
    repeat (4) @(negedge clk);
    read_check("per_count4", 4'hC, 32'd4);
    check("per_single_strobe", n_strobe - base, 32'd1);

    // --- one-shot mode ---
    do_reset();
    use_model = 1'b1;
    bus_write(4'h4, 32'd3);
    bus_write(4'h0, 32'h5);
    check("os_val", timer_set_val, 32'd3);
    repeat (5) @(negedge clk);
    check("os_park_strobe", {31'd0, set_timer}, 32'd1);
    check("os_park_val", timer_set_val, PARK);
    check("os_irq", {31'd0, irq}, 32'd1);
    use_model = 1'b0;
    pulse_once();
    pulse_once();
    read_check("os_ctrl", 4'h0, 32'h4);
    read_check("os_count", 4'hC, 32'd1);
    read_check("os_status", 4'h8, 32'd1);

    // --- set-wins races ---
    do_reset();
    use_model = 1'b0;
    bus_write(4'h0, 32'h7);
    @(negedge clk);
    pulse_once();
    @(negedge clk);
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = 4'h8; bus_if.bus_wdata = 32'h1;
    manual_pulse = 1'b1;
    @(negedge clk);
    bus_idle(); manual_pulse = 1'b0;
    check("race_irq", {31'd0, irq}, 32'd1);
`ifdef TIMER_IRQ_OVERRUN_EN
    exp_st = 32'h3;
`else
    exp_st = 32'h1;
`endif
    read_check("race_status", 4'h8, exp_st);
    read_check("race_count2", 4'hC, 32'd2);
    @(negedge clk);
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = 4'hC; bus_if.bus_wdata = 32'h0;
    manual_pulse = 1'b1;
    @(negedge clk);
    bus_idle(); manual_pulse = 1'b0;
    read_check("race_count_clr", 4'hC, 32'd1);
    bus_write(4'h8, 32'h3);
    read_check("race_status_clr", 4'h8, 32'h0);

    // --- re-arm while running ---
    do_reset();
    use_model = 1'b1;
    bus_write(4'h4, 32'd100);
    bus_write(4'h0, 32'h5);
    repeat (5) @(negedge clk);
    bus_write(4'h4, 32'd10);
    check("rearm_strobe", {31'd0, set_timer}, 32'd1);
    check("rearm_val", timer_set_val, 32'd10);
    wait_irq(k);
    check("rearm_delay", k, 32'd12);
    read_check("rearm_count", 4'hC, 32'd1);

    // --- COUNT saturation ---
    do_reset();
    use_model = 1'b0;
    bus_write(4'h0, 32'h3);
    @(negedge clk);
    for (int i = 0; i < 17; i++) pulse_once();
    read_check("sat_count", 4'hC, 32'hF);
    bus_write(4'hC, 32'h0);
    read_check("sat_clear", 4'hC, 32'h0);

    // --- randomized run against the reference model ---
    do_reset();
    use_model = 1'b0;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      logic        req, we, tih;
      logic [3:0]  a;
      logic [31:0] wd;
      int          r;
      @(negedge clk);
      check("rnd_set_timer", {31'd0, set_timer}, {31'd0, m_strobe != 0});
      check("rnd_set_val", timer_set_val,
            (m_strobe == 1) ? m_load : (m_strobe == 2) ? PARK : 32'h0);
      check("rnd_irq", {31'd0, irq}, {31'd0, m_pend & m_ie});
      check("rnd_ack", {31'd0, bus_if.bus_ack}, {31'd0, m_ack});
      if (m_rd) check("rnd_rdata", bus_if.bus_rdata, m_rdata);
      r   = $urandom_range(0, 99);
      wd  = $urandom;
      a   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                         : {2'($urandom_range(0, 3)), 2'b00};
      req = 1'b1;
      we  = 1'b1;
      if (r < 35)      req = 1'b0;
      else if (r < 60) we = 1'b0;
      else if (r < 68) a = 4'h0;
      else if (r < 76) begin a = 4'h4; wd = 32'($urandom_range(0, 20)); end
      else if (r < 88) a = 4'h8;
      else if (r < 92) a = 4'hC;
      if (!req) begin we = 1'b0; a = 4'h0; wd = 32'h0; end
      tih = ($urandom_range(0, 3) == 0);
      bus_if.bus_req = req; bus_if.bus_we = we; bus_if.bus_addr = a; bus_if.bus_wdata = wd;
      manual_pulse = tih;
      model_step(req, we, a, wd, tih);
    end
    @(negedge clk);
    bus_idle();
    manual_pulse = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
